// File: rtl/rr_arb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_mux_pkg
//  Description : Shared types for the arbitrated stream multiplexer:
//                arbitration mode and output-stage state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package rr_arb_mux_pkg;

    // Arbitration policy selected by the mode input
    typedef enum logic {
        ARB_FIXED = 1'b0,   // lowest requesting index wins
        ARB_RR    = 1'b1    // search starts at the round-robin pointer
    } arb_mode_e;

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage : rr_arb_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational one-hot arbiter. Fixed mode picks the lowest
//                requesting index; round-robin mode searches from ptr upward,
//                wrapping explicitly at N_CH so non-power-of-2 counts work.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  arb_mode_e       mode,
    input  logic            en,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    // One extra bit so start + offset cannot overflow before the wrap
    localparam logic [CH_W:0] N_CH_EXT = (CH_W+1)'(N_CH);

    logic [CH_W:0] start;
    logic [CH_W:0] cand;
    logic          found;

    // Priority search over all offsets from the start channel, first hit wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // An out-of-range pointer can never be loaded, but fall back to 0 anyway
        if (mode == ARB_RR && {1'b0, ptr} < N_CH_EXT) begin
            start = {1'b0, ptr};
        end else begin
            start = '0;
        end
        for (int i = 0; i < N_CH; i++) begin
            cand = start + (CH_W+1)'(i);
            if (cand >= N_CH_EXT) begin
                cand = cand - N_CH_EXT;
            end
            if (en && !found && req[cand[CH_W-1:0]]) begin
                grant[cand[CH_W-1:0]] = 1'b1;
                grant_idx             = cand[CH_W-1:0];
                found                 = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_mux
//  Description : N-channel valid/ready stream multiplexer. An arbiter picks
//                one requesting channel per transfer; the winning word is
//                registered together with its source channel index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    out_state_e       state;
    logic [CH_W-1:0]  ptr;
    logic             can_load;
    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grant_idx;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    // The register can accept a word when empty or when it drains this cycle;
    // reset is folded in so in_ready is forced low while rst is high
    assign can_load = !rst && ((state == EMPTY) || out_ready);

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .mode      (arb_mode_e'(mode)),
        .en        (can_load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is already gated by can_load and only lands on requesting channels
    assign in_ready = grant;
    assign xfer     = |(in_valid & in_ready);

    // One-hot AND-OR select of the winning channel's data
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant[k]) begin
                sel_data = sel_data | in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output FSM, data/channel register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            state    <= FULL;
            out_data <= sel_data;
            out_ch   <= grant_idx;
            ptr      <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end else if (state == FULL && out_ready) begin
            state    <= EMPTY;
        end
    end

    assign out_valid = (state == FULL);

endmodule : rr_arb_mux
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb_mux
//  Description : Directed self-checking bench for rr_arb_mux, covering a
//                4-channel/8-bit and a 3-channel/16-bit instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 4-channel, 8-bit instance
    logic        mode4;
    logic [3:0]  in_valid4;
    logic [31:0] in_data4;
    logic [3:0]  in_ready4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic [1:0]  out_ch4;
    logic        out_ready4;

    // 3-channel, 16-bit instance
    logic        mode3;
    logic [2:0]  in_valid3;
    logic [47:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [15:0] out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    int tests = 0;
    int fails = 0;

    logic [9:0]  q4[$];
    logic [17:0] q3[$];
    logic [9:0]  held4;
    logic [17:0] held3;

    always #5 clk = ~clk;

    rr_arb_mux #(.N_CH(4), .WIDTH(8)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode4),
        .in_valid  (in_valid4),
        .in_data   (in_data4),
        .in_ready  (in_ready4),
        .out_valid (out_valid4),
        .out_data  (out_data4),
        .out_ch    (out_ch4),
        .out_ready (out_ready4)
    );

    rr_arb_mux #(.N_CH(3), .WIDTH(16)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_ready (out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 4-channel DUT; called just after inputs change at negedge
    task automatic step4(input string tag, input logic [3:0] exp_rdy, input bit xfer,
                         input int ech, input logic [7:0] edata, input bit exp_ov);
        logic [9:0] e;
        #1;
        chk({tag, ".in_ready"}, {28'd0, in_ready4}, {28'd0, exp_rdy});
        if (xfer) q4.push_back({ech[1:0], edata});
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {31'd0, out_valid4}, {31'd0, exp_ov});
        if (xfer) begin
            e = q4.pop_front();
            held4 = e;
            chk({tag, ".out_ch"}, {30'd0, out_ch4}, {30'd0, e[9:8]});
            chk({tag, ".out_data"}, {24'd0, out_data4}, {24'd0, e[7:0]});
        end else if (exp_ov) begin
            chk({tag, ".hold_data"}, {24'd0, out_data4}, {24'd0, held4[7:0]});
            chk({tag, ".hold_ch"}, {30'd0, out_ch4}, {30'd0, held4[9:8]});
        end
        @(negedge clk);
    endtask

    // One transferring cycle on the 3-channel DUT
    task automatic step3(input string tag, input logic [2:0] exp_rdy,
                         input int ech, input logic [15:0] edata);
        logic [17:0] e;
        #1;
        chk({tag, ".in_ready"}, {29'd0, in_ready3}, {29'd0, exp_rdy});
        q3.push_back({ech[1:0], edata});
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {31'd0, out_valid3}, 32'd1);
        e = q3.pop_front();
        held3 = e;
        chk({tag, ".out_ch"}, {30'd0, out_ch3}, {30'd0, e[17:16]});
        chk({tag, ".out_data"}, {16'd0, out_data3}, {16'd0, e[15:0]});
        @(negedge clk);
    endtask

    initial begin
        mode4      = 1'b0;
        in_valid4  = 4'b1111;
        in_data4   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        out_ready4 = 1'b1;
        mode3      = 1'b1;
        in_valid3  = 3'b000;
        in_data3   = {16'h3333, 16'h2222, 16'h1111};
        out_ready3 = 1'b1;
        held4      = '0;
        held3      = '0;

        // Reset state with requests pending
        #3;
        chk("rst.out_valid", {31'd0, out_valid4}, 32'd0);
        chk("rst.out_data", {24'd0, out_data4}, 32'd0);
        chk("rst.out_ch", {30'd0, out_ch4}, 32'd0);
        chk("rst.in_ready", {28'd0, in_ready4}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fixed priority: channel 0 always wins
        step4("fix0", 4'b0001, 1, 0, 8'hA0, 1);
        step4("fix1", 4'b0001, 1, 0, 8'hA0, 1);
        step4("fix2", 4'b0001, 1, 0, 8'hA0, 1);

        // Asynchronous reset mid-cycle while FULL
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", {31'd0, out_valid4}, 32'd0);
        chk("arst.out_data", {24'd0, out_data4}, 32'd0);
        chk("arst.in_ready", {28'd0, in_ready4}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin, all valid: 0,1,2,3,0 back to back
        mode4 = 1'b1;
        step4("rr0", 4'b0001, 1, 0, 8'hA0, 1);
        step4("rr1", 4'b0010, 1, 1, 8'hB1, 1);
        step4("rr2", 4'b0100, 1, 2, 8'hC2, 1);
        step4("rr3", 4'b1000, 1, 3, 8'hD3, 1);
        step4("rr4", 4'b0001, 1, 0, 8'hA0, 1);

        // Backpressure: word 5A from channel 1 held for three cycles
        in_data4 = {8'hD3, 8'hC2, 8'h5A, 8'hA0};
        step4("bp_load", 4'b0010, 1, 1, 8'h5A, 1);
        out_ready4 = 1'b0;
        step4("bp_h0", 4'b0000, 0, 0, 8'h00, 1);
        step4("bp_h1", 4'b0000, 0, 0, 8'h00, 1);
        step4("bp_h2", 4'b0000, 0, 0, 8'h00, 1);
        out_ready4 = 1'b1;
        step4("bp_next", 4'b0100, 1, 2, 8'hC2, 1);

        // Sparse round-robin: move ptr to 2, then only channels 0 and 1 request
        in_valid4 = 4'b0010;
        step4("sp_set", 4'b0010, 1, 1, 8'h5A, 1);
        in_valid4 = 4'b0011;
        step4("sp0", 4'b0001, 1, 0, 8'hA0, 1);
        step4("sp1", 4'b0010, 1, 1, 8'h5A, 1);

        // No requests: register drains to EMPTY
        in_valid4 = 4'b0000;
        step4("drain", 4'b0000, 0, 0, 8'h00, 0);

        // Mode change is combinational into the grant (ptr is 2 here)
        in_valid4 = 4'b1111;
        #1;
        chk("mode_rr.in_ready", {28'd0, in_ready4}, 32'd4);
        mode4 = 1'b0;
        #1;
        chk("mode_fix.in_ready", {28'd0, in_ready4}, 32'd1);
        in_valid4 = 4'b0000;
        @(negedge clk);

        // Non-power-of-2 wrap on the 3-channel instance
        in_valid3 = 3'b111;
        step3("n3_0", 3'b001, 0, 16'h1111);
        step3("n3_1", 3'b010, 1, 16'h2222);
        step3("n3_2", 3'b100, 2, 16'h3333);
        step3("n3_3", 3'b001, 0, 16'h1111);
        in_valid3 = 3'b000;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rr_arb_mux
`default_nettype wire

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel selector that generalises the combinational 4:1 mux into an arbitrated, registered stream multiplexer. Each input channel offers data with a valid/ready handshake. An internal arbiter picks one requesting channel per transfer, using either fixed priority or round-robin. The winning word is captured into a single output register stage, tagged with its source channel, for downstream consumers.

## Interface
- `N_CH`, default 4: number of input channels; legal range 2..16.
- `WIDTH`, default 8: data width per channel, in bits.
- `CH_W`, default `$clog2(N_CH)`: width of the channel index; derived, not to be overridden.

Ports (clock and reset first):
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mode` in 1: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round-robin.
- `in_valid` in `N_CH`: per-channel request; bit k belongs to channel k.
- `in_data` in `N_CH*WIDTH`: packed channel data; channel k occupies `[k*WIDTH +: WIDTH]`.
- `in_ready` out `N_CH`: per-channel grant/accept; at most one bit is set.
- `out_valid` out 1: the output register holds a word.
- `out_data` out `WIDTH`: registered data word.
- `out_ch` out `CH_W`: index of the channel that supplied `out_data`.
- `out_ready` in 1: downstream accepts the word.

## Operation
- Output stage is a two-state FSM, `EMPTY` / `FULL`; `out_valid` = (state == `FULL`).
- `can_load` = `EMPTY` or (`FULL` and `out_ready`).
- When `can_load` is set and any `in_valid` bit is set, the arbiter produces a one-hot `grant`. `in_ready` = `grant` when `can_load` is set, otherwise all zeros.
- An input transfer on channel k occurs when `in_valid[k]` and `in_ready[k]` are both set. On that edge:
  - `out_data` <= channel k data;
  - `out_ch` <= k;
  - state <= `FULL`.
- FSM transitions:
  - `FULL` with `out_ready` and no input transfer -> `EMPTY`.
  - `FULL` with `out_ready` and an input transfer -> stays `FULL` with the new word (back-to-back transfer, no bubble).
  - `FULL` without `out_ready` -> hold; `out_data` and `out_ch` stay stable and `in_ready` stays all zeros.
- Fixed mode: grant goes to the lowest-index requesting channel.
- Round-robin mode:
  - A pointer `ptr` (`CH_W` bits) names the highest-priority channel.
  - Search order is `ptr`, `ptr+1`, …, wrapping modulo `N_CH` (wrap-around is explicit, including when `N_CH` is not a power of 2).
  - After a transfer from channel k, `ptr` <= (k+1) mod `N_CH`.
- `ptr` changes only on a transfer. It is kept across mode changes, but fixed mode ignores it.
- A change on `mode` takes effect for the next arbitration, i.e. it is combinational into the grant.
- No request, or `can_load` clear: `grant` = 0 and `ptr` holds.
- `in_valid` on an ungranted channel may drop without effect. Channels that follow the protocol keep `in_valid` and `in_data` stable until they are granted.

## Timing
- Reset values: state `EMPTY`, `out_valid` 0, `out_data` 0, `out_ch` 0, `ptr` 0. `in_ready` is all zeros while `rst` is high.
- Reset asserted mid-transfer discards the held word immediately (asynchronously); no transfer completes on that edge.
- Latency: `in_valid`/`in_ready` transfer at edge n gives `out_valid` = 1 with the data after edge n.
- Throughput: one word per cycle while `out_ready` is held high.
- `in_ready` depends combinationally on `in_valid`, `mode`, `ptr`, state and `out_ready`. There is no combinational path from `in_data` to any output.

## Structure
- Package `rr_arb_mux_pkg` holds:
  - `typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e`;
  - `typedef enum logic {EMPTY, FULL} out_state_e`.
- Sub-module `rr_arbiter` (parameter `N_CH`) is purely combinational:
  - inputs: `req`, `ptr`, `mode`, `en`;
  - output: one-hot `grant` plus its encoded index.
- Top level `rr_arb_mux` holds the output register, the FSM and `ptr`.

## Test plan
- Reset, `N_CH`=4, `WIDTH`=8: drive `rst` high mid-cycle -> `out_valid` 0, `out_data` 0, `in_ready` 0000 without waiting for a clock edge.
- Fixed mode, all four channels valid with data A0, B1, C2, D3, `out_ready` 1 -> outputs on successive cycles are channel 0 / A0 repeated, and `in_ready` stays 0001.
- Round-robin, all valid, `out_ready` 1 -> `out_ch` sequence 0,1,2,3,0 with no idle cycle; `ptr` wraps from 3 to 0.
- Backpressure: `out_ready` 0 for 3 cycles while `FULL` with data 5A -> `out_data` stays 5A and `in_ready` stays 0000. After `out_ready` rises, the next word follows with no bubble.
- Sparse round-robin, `ptr`=2 and only channels 0 and 1 valid -> channel 0 is granted, then `ptr` becomes 1 and channel 1 is granted next.
- `N_CH`=3, `WIDTH`=16, round-robin, all valid -> `out_ch` sequence 0,1,2,0, proving the non-power-of-2 wrap.
